// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the universal counter/shift register.
//   - OP_* : 3-bit operation select produced by counter_op_sel and
//            decoded by counter_univ_param.
//   - maxv : largest value of the count range for a given modulus.
package counter_pkg;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;

  // The count range is 0..modulus-1.
  function automatic int unsigned maxv(input int unsigned modulus);
    return modulus - 32'd1;
  endfunction

endpackage

// File: rtl/counter_op_sel.sv
// counter_op_sel
//   Combinational priority encoder for the counter operation requests.
//   Priority is strict: load > inc > dec > shl > shr > hold.
// Ports
//   load_i, inc_i, dec_i, shl_i, shr_i : operation requests
//   op_o                               : selected operation (counter_pkg::OP_*)
module counter_op_sel
  import counter_pkg::*;
(
  input  logic       load_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       shl_i,
  input  logic       shr_i,
  output logic [2:0] op_o
);

  always_comb begin
    op_o = OP_HOLD;
    if (load_i)     op_o = OP_LOAD;
    else if (inc_i) op_o = OP_INC;
    else if (dec_i) op_o = OP_DEC;
    else if (shl_i) op_o = OP_SHL;
    else if (shr_i) op_o = OP_SHR;
  end

endmodule

// File: rtl/counter_univ_param.sv
// counter_univ_param
//   Parametrised universal counter / shift register with load, increment,
//   decrement, shift left/right (optionally rotating), clock enable,
//   optional saturation and carry/borrow/serial-out flags.
// Parameters
//   WIDTH    : register width (>= 2)
//   MODULUS  : count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE : 0 = INC/DEC wrap at range ends, 1 = hold at MAXV / 0
// Ports
//   C   : clock, rising edge
//   R   : asynchronous active-high reset
//   EN  : clock enable for every operation
//   D   : load data; D[0] serial-in for SHL, D[WIDTH-1] serial-in for SHR
//   L, INC, DEC, SHL, SHR : operation requests (priority in that order)
//   ROT : shifts rotate instead of taking serial-in
//   Q   : register value
//   CO  : carry pulse (INC executed at Q >= MAXV)
//   BO  : borrow pulse (DEC executed at Q == 0)
//   SO  : last bit shifted out
//   TC  : combinational Q >= MAXV
//   ZR  : combinational Q == 0
module counter_univ_param
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MODULUS  = 2**WIDTH,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             L,
  input  logic             INC,
  input  logic             DEC,
  input  logic             SHL,
  input  logic             SHR,
  input  logic             ROT,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             BO,
  output logic             SO,
  output logic             TC,
  output logic             ZR
);

  localparam int unsigned    MAXV_INT = maxv(MODULUS);
  localparam logic [WIDTH-1:0] MAXV   = MAXV_INT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       op;
  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic             bo_q, bo_d;
  logic             so_q, so_d;

  counter_op_sel u_op_sel (
    .load_i (L),
    .inc_i  (INC),
    .dec_i  (DEC),
    .shl_i  (SHL),
    .shr_i  (SHR),
    .op_o   (op)
  );

  // CO/BO default to 0 so they are pulses; Q and SO hold unless an op
  // updates them. EN=0 therefore behaves exactly like OP_HOLD.
  always_comb begin
    q_d  = q_q;
    co_d = 1'b0;
    bo_d = 1'b0;
    so_d = so_q;
    if (EN) begin
      case (op)
        OP_LOAD: q_d = (D > MAXV) ? MAXV : D;
        OP_INC: begin
          // ">=" rather than "==": a shift may have left Q above MAXV,
          // and that is treated as the wrap point.
          if (q_q >= MAXV) begin
            q_d  = SATURATE ? MAXV : ZERO;
            co_d = 1'b1;
          end else begin
            q_d = q_q + ONE;
          end
        end
        OP_DEC: begin
          if (q_q == ZERO) begin
            q_d  = SATURATE ? ZERO : MAXV;
            bo_d = 1'b1;
          end else begin
            q_d = q_q - ONE;
          end
        end
        // Shifts use the full register width and ignore MODULUS.
        OP_SHL: begin
          q_d  = {q_q[WIDTH-2:0], ROT ? q_q[WIDTH-1] : D[0]};
          so_d = q_q[WIDTH-1];
        end
        OP_SHR: begin
          q_d  = {ROT ? q_q[0] : D[WIDTH-1], q_q[WIDTH-1:1]};
          so_d = q_q[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      q_q  <= '0;
      co_q <= 1'b0;
      bo_q <= 1'b0;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
      bo_q <= bo_d;
      so_q <= so_d;
    end
  end

  assign Q  = q_q;
  assign CO = co_q;
  assign BO = bo_q;
  assign SO = so_q;
  assign TC = (q_q >= MAXV);
  assign ZR = (q_q == ZERO);

endmodule
